// File: rtl/ex_mem_reg_pkg.sv
// Shared EX/MEM pipeline definitions: trap FSM states, datapath widths and
// the MEM control bundle ordering {reg_wr, mem_rd, mem_wr, mem2reg}.
package ex_mem_reg_pkg;

  localparam int DW       = 32;
  localparam int RW       = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE      = 1'b0,
    TRAP_PEND = 1'b1
  } trap_state_e;

  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic mem2reg;
  } mem_ctrl_t;

endpackage

// File: rtl/ex_mem_reg_exc_trap_fsm.sv
// Overflow trap tracker: records the faulting PC, raises exc_req and kills
// every instruction entering MEM until the handler acknowledges.
module exc_trap_fsm #(
  parameter int DW = ex_mem_reg_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          stall,
  input  logic          ex_valid,
  input  logic          ex_ovf,
  input  logic          ex_ovf_chk,
  input  logic [DW-1:0] ex_pc,
  input  logic          exc_ack,
  output logic          trap_kill,
  output logic          exc_req,
  output logic [DW-1:0] exc_epc
);
  import ex_mem_reg_pkg::*;

  trap_state_e   state_q, state_d;
  logic [DW-1:0] epc_q, epc_d;
  logic          ovf_trap;

  assign ovf_trap = ex_ovf & ex_ovf_chk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  // A new trap is only taken on an edge that actually loads MEM.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    case (state_q)
      IDLE: begin
        if (!flush && !stall && ex_valid && ovf_trap) begin
          state_d = TRAP_PEND;
          epc_d   = ex_pc;
        end
      end
      TRAP_PEND: begin
        if (exc_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    exc_req   = (state_q == TRAP_PEND);
    trap_kill = ovf_trap | exc_req;
  end

  assign exc_epc = epc_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush and precise overflow traps.
// Define EXMEM_FWD_EN to expose the MEM-stage forwarding outputs.
module ex_mem_reg #(
  parameter int DW = ex_mem_reg_pkg::DW,
  parameter int RW = ex_mem_reg_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_zero,
  input  logic          ex_ovf,
  input  logic          ex_ovf_chk,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_dst,
  input  logic          ex_reg_wr,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic          ex_mem2reg,
  input  logic [DW-1:0] ex_pc,
  input  logic          stall,
  input  logic          flush,
  input  logic          exc_ack,
  output logic          mem_valid,
  output logic [DW-1:0] mem_result,
  output logic [DW-1:0] mem_store_data,
  output logic          mem_zero,
  output logic [RW-1:0] mem_dst,
  output logic          mem_reg_wr,
  output logic          mem_mem_rd,
  output logic          mem_mem_wr,
  output logic          mem_mem2reg,
  output logic          exc_req,
  output logic [DW-1:0] exc_epc
`ifdef EXMEM_FWD_EN
  ,
  output logic          fwd_en,
  output logic [RW-1:0] fwd_dst,
  output logic [DW-1:0] fwd_data
`endif
);
  import ex_mem_reg_pkg::*;

  logic          valid_q, valid_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] store_q, store_d;
  logic          zero_q, zero_d;
  logic [RW-1:0] dst_q, dst_d;
  mem_ctrl_t     ctrl_q, ctrl_d;
  mem_ctrl_t     ex_ctrl;
  logic          trap_kill;
  logic          live;

  exc_trap_fsm #(.DW(DW)) u_trap (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_ovf     (ex_ovf),
    .ex_ovf_chk (ex_ovf_chk),
    .ex_pc      (ex_pc),
    .exc_ack    (exc_ack),
    .trap_kill  (trap_kill),
    .exc_req    (exc_req),
    .exc_epc    (exc_epc)
  );

  assign ex_ctrl = {ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_mem2reg};
  assign live    = ex_valid & ~trap_kill;

  // Killed instructions still load result/zero/dst so they stay visible for debug.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    zero_d   = zero_q;
    dst_d    = dst_q;
    ctrl_d   = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall) begin
      valid_d  = live;
      ctrl_d   = live ? ex_ctrl : '0;
      result_d = ex_result;
      store_d  = ex_store_data;
      zero_d   = ex_zero;
      dst_d    = ex_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      zero_q   <= 1'b0;
      dst_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      zero_q   <= zero_d;
      dst_q    <= dst_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_store_data = store_q;
  assign mem_zero       = zero_q;
  assign mem_dst        = dst_q;
  assign mem_reg_wr     = ctrl_q.reg_wr;
  assign mem_mem_rd     = ctrl_q.mem_rd;
  assign mem_mem_wr     = ctrl_q.mem_wr;
  assign mem_mem2reg    = ctrl_q.mem2reg;

`ifdef EXMEM_FWD_EN
  assign fwd_en   = valid_q & ctrl_q.reg_wr & ~ctrl_q.mem2reg & (dst_q != RW'(REG_ZERO));
  assign fwd_dst  = dst_q;
  assign fwd_data = result_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vectors with literal checks
// plus a per-cycle comparison against a behavioural pipeline/trap model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_zero, ex_ovf, ex_ovf_chk;
  logic [31:0] ex_result, ex_store_data, ex_pc;
  logic [4:0]  ex_dst;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_mem2reg;
  logic        stall, flush, exc_ack;
  logic        mem_valid, mem_zero, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_mem2reg;
  logic [31:0] mem_result, mem_store_data, exc_epc;
  logic [4:0]  mem_dst;
  logic        exc_req;
`ifdef EXMEM_FWD_EN
  logic        fwd_en;
  logic [4:0]  fwd_dst;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_result      (ex_result),
    .ex_zero        (ex_zero),
    .ex_ovf         (ex_ovf),
    .ex_ovf_chk     (ex_ovf_chk),
    .ex_store_data  (ex_store_data),
    .ex_dst         (ex_dst),
    .ex_reg_wr      (ex_reg_wr),
    .ex_mem_rd      (ex_mem_rd),
    .ex_mem_wr      (ex_mem_wr),
    .ex_mem2reg     (ex_mem2reg),
    .ex_pc          (ex_pc),
    .stall          (stall),
    .flush          (flush),
    .exc_ack        (exc_ack),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_zero       (mem_zero),
    .mem_dst        (mem_dst),
    .mem_reg_wr     (mem_reg_wr),
    .mem_mem_rd     (mem_mem_rd),
    .mem_mem_wr     (mem_mem_wr),
    .mem_mem2reg    (mem_mem2reg),
    .exc_req        (exc_req),
    .exc_epc        (exc_epc)
`ifdef EXMEM_FWD_EN
    ,
    .fwd_en         (fwd_en),
    .fwd_dst        (fwd_dst),
    .fwd_data       (fwd_data)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what MEM must hold after each edge.
  bit          chk_en = 0;
  bit          m_valid, m_zero, m_pend, m_data_known;
  logic [31:0] m_result, m_store, m_epc;
  logic [4:0]  m_dst;
  logic [3:0]  m_ctrl;  // {reg_wr, mem_rd, mem_wr, mem2reg}

  always @(posedge clk) begin
    bit ovf, killed, new_trap;
    if (!rst_n) begin
      m_valid = 0; m_zero = 0; m_pend = 0; m_result = 0; m_store = 0;
      m_epc = 0; m_dst = 0; m_ctrl = 0; m_data_known = 1; chk_en = 1;
    end else begin
      ovf      = ex_ovf && ex_ovf_chk;
      new_trap = 0;
      if (flush) begin
        m_valid = 0; m_ctrl = 0; m_data_known = 0;
      end else if (!stall) begin
        killed       = m_pend || ovf;
        m_valid      = ex_valid && !killed;
        m_ctrl       = m_valid ? {ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_mem2reg} : 4'b0;
        m_result     = ex_result;
        m_store      = ex_store_data;
        m_zero       = ex_zero;
        m_dst        = ex_dst;
        m_data_known = 1;
        new_trap     = !m_pend && ex_valid && ovf;
      end
      if (m_pend && exc_ack) m_pend = 0;
      else if (new_trap) begin
        m_pend = 1;
        m_epc  = ex_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", mem_valid, m_valid);
      check("cyc_ctrl", {mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_mem2reg}, m_ctrl);
      check("cyc_exc_req", exc_req, m_pend);
      check("cyc_exc_epc", exc_epc, m_epc);
      if (m_data_known) begin
        check("cyc_result", mem_result, m_result);
        check("cyc_store", mem_store_data, m_store);
        check("cyc_zero", mem_zero, m_zero);
        check("cyc_dst", mem_dst, m_dst);
      end
`ifdef EXMEM_FWD_EN
      check("cyc_fwd_en", fwd_en, m_valid && m_ctrl[3] && !m_ctrl[0] && (m_dst != 0));
      if (m_data_known) begin
        check("cyc_fwd_dst", fwd_dst, m_dst);
        check("cyc_fwd_data", fwd_data, m_result);
      end
`endif
    end
  end

  task automatic clr();
    ex_valid = 0; ex_zero = 0; ex_ovf = 0; ex_ovf_chk = 0;
    ex_result = 0; ex_store_data = 0; ex_pc = 0; ex_dst = 0;
    ex_reg_wr = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_mem2reg = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; exc_ack = 0;
    clr();
    step(); step();
    check("rst_valid", mem_valid, 0);
    check("rst_exc_req", exc_req, 0);
    check("rst_exc_epc", exc_epc, 0);
    rst_n = 1;

    // Normal load
    ex_valid = 1; ex_result = 32'h10; ex_dst = 8; ex_reg_wr = 1; ex_pc = 32'h0040_0000;
    step();
    check("load_valid", mem_valid, 1);
    check("load_result", mem_result, 32'h10);
    check("load_dst", mem_dst, 8);
    check("load_reg_wr", mem_reg_wr, 1);
    check("load_exc_req", exc_req, 0);

    // Overflow trap
    clr(); ex_valid = 1; ex_ovf = 1; ex_ovf_chk = 1; ex_pc = 32'h0040_0020;
    ex_reg_wr = 1; ex_result = 32'h7fff_fff0; ex_dst = 3;
    step();
    check("trap_valid", mem_valid, 0);
    check("trap_reg_wr", mem_reg_wr, 0);
    check("trap_exc_req", exc_req, 1);
    check("trap_epc", exc_epc, 32'h0040_0020);
    check("trap_dbg_result", mem_result, 32'h7fff_fff0);
    check("trap_dbg_dst", mem_dst, 3);

    for (int i = 0; i < 2; i++) begin
      clr(); ex_valid = 1; ex_reg_wr = 1; ex_mem_wr = 1;
      ex_pc = 32'h0040_0024 + 32'(4 * i); ex_result = 32'(i);
      step();
      check("squash_valid", mem_valid, 0);
      check("squash_mem_wr", mem_mem_wr, 0);
      check("squash_epc", exc_epc, 32'h0040_0020);
    end

    clr(); ex_valid = 1; ex_reg_wr = 1; ex_pc = 32'h0040_002c; exc_ack = 1;
    step();
    exc_ack = 0;
    check("ack_exc_req", exc_req, 0);
    check("ack_edge_squashed", mem_valid, 0);

    clr(); ex_valid = 1; ex_reg_wr = 1; ex_dst = 4; ex_result = 32'h55;
    step();
    check("post_ack_valid", mem_valid, 1);
    check("post_ack_reg_wr", mem_reg_wr, 1);

    // Ack while idle is ignored
    clr(); exc_ack = 1; ex_valid = 1; ex_mem_rd = 1; ex_mem2reg = 1; ex_dst = 5;
    step();
    exc_ack = 0;
    check("idle_ack_valid", mem_valid, 1);
    check("idle_ack_mem_rd", mem_mem_rd, 1);
    check("idle_ack_mem2reg", mem_mem2reg, 1);
    check("idle_ack_exc_req", exc_req, 0);

    // Stall freezes MEM and does not sample overflow
    clr(); ex_valid = 1; ex_result = 32'hA5A5_0001; ex_store_data = 32'h1234_5678;
    ex_dst = 7; ex_mem_wr = 1; ex_zero = 1;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      clr(); ex_valid = 1; ex_result = 32'hBEEF_0000 + 32'(i); ex_dst = 5'(10 + i);
      ex_reg_wr = 1; ex_ovf = (i == 1); ex_ovf_chk = 1;
      step();
      check("stall_result", mem_result, 32'hA5A5_0001);
      check("stall_store", mem_store_data, 32'h1234_5678);
      check("stall_mem_wr", mem_mem_wr, 1);
      check("stall_zero", mem_zero, 1);
      check("stall_exc_req", exc_req, 0);
    end

    // Flush beats stall, and beats an overflow on the same edge
    flush = 1;
    clr(); ex_valid = 1; ex_ovf = 1; ex_ovf_chk = 1; ex_reg_wr = 1; ex_pc = 32'h0040_0100;
    step();
    check("flush_valid", mem_valid, 0);
    check("flush_mem_wr", mem_mem_wr, 0);
    check("flush_reg_wr", mem_reg_wr, 0);
    check("flush_exc_req", exc_req, 0);
    stall = 0; flush = 0;

    // Unsigned overflow passes through
    clr(); ex_valid = 1; ex_ovf = 1; ex_ovf_chk = 0; ex_mem_wr = 1; ex_store_data = 32'hCAFE;
    step();
    check("unsigned_mem_wr", mem_mem_wr, 1);
    check("unsigned_valid", mem_valid, 1);
    check("unsigned_exc_req", exc_req, 0);

    // Overflow on a bubble is ignored
    clr(); ex_ovf = 1; ex_ovf_chk = 1; ex_pc = 32'h200;
    step();
    check("bubble_ovf_exc_req", exc_req, 0);
    check("bubble_ovf_valid", mem_valid, 0);

    // Ack during stall still releases the trap
    clr(); ex_valid = 1; ex_ovf = 1; ex_ovf_chk = 1; ex_pc = 32'h0040_0200;
    step();
    check("trap2_exc_req", exc_req, 1);
    stall = 1; exc_ack = 1;
    clr(); ex_valid = 1;
    step();
    stall = 0; exc_ack = 0;
    check("stall_ack_exc_req", exc_req, 0);

    // Reset mid-trap
    clr(); ex_valid = 1; ex_ovf = 1; ex_ovf_chk = 1; ex_pc = 32'h0040_0300; ex_result = 32'h99;
    step();
    check("trap3_exc_req", exc_req, 1);
    check("trap3_epc", exc_epc, 32'h0040_0300);
    rst_n = 0;
    clr(); ex_valid = 1; ex_reg_wr = 1;
    step();
    rst_n = 1;
    check("midrst_exc_req", exc_req, 0);
    check("midrst_epc", exc_epc, 0);
    check("midrst_valid", mem_valid, 0);
    check("midrst_result", mem_result, 0);
    check("midrst_reg_wr", mem_reg_wr, 0);

    clr(); ex_valid = 1; ex_reg_wr = 1; ex_dst = 9; ex_result = 32'h77;
    step();
    check("after_rst_valid", mem_valid, 1);
    check("after_rst_result", mem_result, 32'h77);
`ifdef EXMEM_FWD_EN
    check("fwd_en_dst9", fwd_en, 1);
    check("fwd_dst_dst9", fwd_dst, 9);
    check("fwd_data_dst9", fwd_data, 32'h77);
    clr(); ex_valid = 1; ex_reg_wr = 1; ex_dst = 0; ex_result = 32'h88;
    step();
    check("fwd_en_dst0", fwd_en, 0);
`endif

    // Mixed traffic swept against the model
    for (int i = 0; i < 80; i++) begin
      clr();
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_result     = $urandom;
      ex_store_data = $urandom;
      ex_zero       = 1'($urandom_range(0, 1));
      ex_dst        = 5'($urandom_range(0, 31));
      ex_pc         = 32'h0041_0000 + 32'(4 * i);
      ex_ovf        = ($urandom_range(0, 5) == 0);
      ex_ovf_chk    = 1'($urandom_range(0, 1));
      ex_reg_wr     = 1'($urandom_range(0, 1));
      ex_mem_rd     = 1'($urandom_range(0, 1));
      ex_mem_wr     = 1'($urandom_range(0, 1));
      ex_mem2reg    = 1'($urandom_range(0, 1));
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      exc_ack       = ($urandom_range(0, 3) == 0);
      step();
    end
    stall = 0; flush = 0; exc_ack = 0;
    clr();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
